// File: rtl/sd_reg_wr_arbiter.sv
// Register-file write arbiter: round-robin grant across the requesters with an
// optional bounded lock, feeding one registered write port into the register bank.
module sd_reg_wr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8,
  parameter int IDX_W    = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ*DATA_W-1:0]   req_mask,
  output logic [N_REQ-1:0]          gnt,
  output logic                      reg_wr_en,
  output logic [ADDR_W-1:0]         reg_wr_addr,
  output logic [DATA_W-1:0]         reg_wr_data,
  output logic [DATA_W-1:0]         reg_wr_mask,
  output logic                      locked,
  output logic [IDX_W-1:0]          lock_owner
);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // The lock is released on the edge where the counter reaches this value.
  localparam logic [7:0] LOCK_CNT_LAST = 8'(LOCK_MAX - 1);
  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(N_REQ - 1);

  state_t              state_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [7:0]          lock_cnt_q;
  logic [IDX_W-1:0]    lock_owner_q;
  logic                reg_wr_en_q;
  logic [ADDR_W-1:0]   reg_wr_addr_q;
  logic [DATA_W-1:0]   reg_wr_data_q;
  logic [DATA_W-1:0]   reg_wr_mask_q;

  // Unflattened per-requester write payloads.
  logic [ADDR_W-1:0]   addr_arr [N_REQ];
  logic [DATA_W-1:0]   data_arr [N_REQ];
  logic [DATA_W-1:0]   mask_arr [N_REQ];

  // Grant decision for the current cycle.
  logic                gnt_any;
  logic [IDX_W-1:0]    gnt_idx;
  logic [IDX_W-1:0]    cand;
  logic                hs;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      assign mask_arr[gi] = req_mask[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Pick the grantee: rotating search after rr_ptr in ARB, owner-only in LOCKED.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    gnt     = '0;
    if (!RESET) begin
      if (state_q == ST_ARB) begin
        for (int off = 1; off <= N_REQ; off++) begin
          cand = IDX_W'((int'(rr_ptr_q) + off) % N_REQ);
          if (!gnt_any && req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
          end
        end
      end else begin
        // An idle owner keeps the lock; nobody else is served meanwhile.
        if (req[lock_owner_q]) begin
          gnt_any = 1'b1;
          gnt_idx = lock_owner_q;
        end
      end
      if (gnt_any) begin
        gnt[gnt_idx] = 1'b1;
      end
    end
  end

  // A grant is only ever given to an asserted request, so a grant is a handshake.
  assign hs = gnt_any;

  // Arbitration FSM, lock counter and the registered write port.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_ARB;
      rr_ptr_q      <= RR_RESET;
      lock_cnt_q    <= '0;
      lock_owner_q  <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_addr_q <= '0;
      reg_wr_data_q <= '0;
      reg_wr_mask_q <= '0;
    end else begin
      reg_wr_en_q <= hs;
      if (hs) begin
        reg_wr_addr_q <= addr_arr[gnt_idx];
        reg_wr_data_q <= data_arr[gnt_idx];
        reg_wr_mask_q <= mask_arr[gnt_idx];
        rr_ptr_q      <= gnt_idx;
        lock_owner_q  <= gnt_idx;
      end
      case (state_q)
        ST_ARB: begin
          if (hs && req_lock[gnt_idx]) begin
            state_q    <= ST_LOCKED;
            lock_cnt_q <= 8'd1;
          end
        end
        ST_LOCKED: begin
          // Release on an unlocked owner write or when the hold budget runs out;
          // a write on the forced-release edge is still performed above.
          if ((hs && !req_lock[gnt_idx]) || (lock_cnt_q == LOCK_CNT_LAST)) begin
            state_q    <= ST_ARB;
            lock_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q    <= ST_ARB;
          lock_cnt_q <= '0;
        end
      endcase
    end
  end

  assign reg_wr_en   = reg_wr_en_q;
  assign reg_wr_addr = reg_wr_addr_q;
  assign reg_wr_data = reg_wr_data_q;
  assign reg_wr_mask = reg_wr_mask_q;
  assign locked      = (state_q == ST_LOCKED);
  assign lock_owner  = lock_owner_q;

endmodule
